pipeline_hazard_ctrl: RTL and testbench

// Stall/flush controller for the 5-stage RV32I pipeline; sequences the ALU in EXE.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FREEZE     = 2'd1,
    PEND_REDIR = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: the ID instruction reads the register that the load in EXE will write.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  exe_valid,
  input  logic [REG_ADDR_W-1:0] exe_rd_addr,
  input  logic                  exe_mem_read,
  output logic                  load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_use_rs1 & (id_rs1_addr == exe_rd_addr);
  assign rs2_hit  = id_use_rs2 & (id_rs2_addr == exe_rd_addr);
  // x0 is hardwired to zero, so a load into it never creates a dependency
  assign load_use = exe_valid & exe_mem_read & (exe_rd_addr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: freeze, redirect, load-use bubble, perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = pipeline_hazard_ctrl_pkg::CNT_W_DEF,
  parameter int REG_ADDR_W = pipeline_hazard_ctrl_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  exe_valid,
  input  logic [REG_ADDR_W-1:0] exe_rd_addr,
  input  logic                  exe_mem_read,
  input  logic                  exe_jump_sel,
  input  logic                  imem_wait,
  input  logic                  dmem_wait,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_exe_stall,
  output logic                  exe_mem_stall,
  output logic                  mem_wb_stall,
  output logic                  if_id_flush,
  output logic                  id_exe_flush,
  output logic                  pc_redirect,
  output logic                  alu_enable,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  import pipeline_hazard_ctrl_pkg::*;

  hz_state_e        state_q, state_d;
  logic             pend_q, pend_d;
  logic             taken_seen_q, taken_seen_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             freeze, load_use, taken, redirect_req;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .exe_valid    (exe_valid),
    .exe_rd_addr  (exe_rd_addr),
    .exe_mem_read (exe_mem_read),
    .load_use     (load_use)
  );

  assign freeze       = imem_wait | dmem_wait;
  // taken_seen masks a jump_sel that is still held by an EXE instruction already redirected
  assign taken        = exe_valid & exe_jump_sel & ~taken_seen_q;
  assign redirect_req = taken | pend_q;
  assign alu_enable   = exe_valid & rst_n;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_exe_stall  = 1'b0;
    exe_mem_stall = 1'b0;
    mem_wb_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    pc_redirect   = 1'b0;
    pend_d        = pend_q;

    if (!rst_n) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (freeze) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_exe_stall  = 1'b1;
      exe_mem_stall = 1'b1;
      mem_wb_stall  = 1'b1;
      pend_d        = pend_q | taken;
    end else if (redirect_req) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
      pend_d       = 1'b0;
    end else if (load_use) begin
      // one bubble: hold PC and IF/ID, let the load move on to MEM
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_exe_flush = 1'b1;
    end

    if (taken)
      taken_seen_d = 1'b1;
    else if (!id_exe_stall)
      taken_seen_d = 1'b0;
    else
      taken_seen_d = taken_seen_q;

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (pc_redirect && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:        if (freeze) state_d = FREEZE;
      FREEZE:     if (!freeze) state_d = pend_q ? PEND_REDIR : RUN;
      PEND_REDIR: state_d = freeze ? FREEZE : RUN;
      default:    state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pend_q       <= 1'b0;
      taken_seen_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      taken_seen_q <= taken_seen_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (4-bit counters to reach saturation quickly).
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  // {pc, if_id, id_exe, exe_mem, mem_wb stalls, if_id_flush, id_exe_flush, pc_redirect, alu_enable}
  localparam logic [8:0] C_NONE = 9'b00000_00_0_0;
  localparam logic [8:0] C_IDLE = 9'b00000_00_0_1;
  localparam logic [8:0] C_LU   = 9'b11000_01_0_1;
  localparam logic [8:0] C_RD   = 9'b00000_11_1_1;
  localparam logic [8:0] C_FRZ  = 9'b11111_00_0_1;
  localparam logic [8:0] C_RST  = 9'b00000_11_0_0;

  typedef struct {
    string          tag;
    logic [8:0]     ctl;
    logic [CW-1:0]  sc;
    logic [CW-1:0]  fc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1_addr = '0, id_rs2_addr = '0, exe_rd_addr = '0;
  logic          id_use_rs1 = 0, id_use_rs2 = 0, exe_valid = 0, exe_mem_read = 0;
  logic          exe_jump_sel = 0, imem_wait = 0, dmem_wait = 0;
  logic          pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall;
  logic          if_id_flush, id_exe_flush, pc_redirect, alu_enable;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0]    ctl;

  exp_t sb[$];
  exp_t mon_e;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CW), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .exe_valid     (exe_valid),
    .exe_rd_addr   (exe_rd_addr),
    .exe_mem_read  (exe_mem_read),
    .exe_jump_sel  (exe_jump_sel),
    .imem_wait     (imem_wait),
    .dmem_wait     (dmem_wait),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .id_exe_stall  (id_exe_stall),
    .exe_mem_stall (exe_mem_stall),
    .mem_wb_stall  (mem_wb_stall),
    .if_id_flush   (if_id_flush),
    .id_exe_flush  (id_exe_flush),
    .pc_redirect   (pc_redirect),
    .alu_enable    (alu_enable),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  assign ctl = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall,
                if_id_flush, id_exe_flush, pc_redirect, alu_enable};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must show at the next falling edge
  task automatic drv(input string tag, input logic r,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                     input logic ev, input logic [4:0] rd, input logic mr, input logic js,
                     input logic iw, input logic dw,
                     input logic [8:0] ec, input logic [CW-1:0] es, input logic [CW-1:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; id_rs1_addr = rs1; id_rs2_addr = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    exe_valid = ev; exe_rd_addr = rd; exe_mem_read = mr; exe_jump_sel = js;
    imem_wait = iw; dmem_wait = dw;
    e.tag = tag; e.ctl = ec; e.sc = es; e.fc = ef;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, "_ctl"},  32'(ctl),       32'(mon_e.ctl));
      chk({mon_e.tag, "_scnt"}, 32'(stall_cnt), 32'(mon_e.sc));
      chk({mon_e.tag, "_fcnt"}, 32'(flush_cnt), 32'(mon_e.fc));
    end
  end

  initial begin
    //   tag          rst rs1 rs2 u1 u2 ev rd mr js iw dw  exp     sc  fc
    drv("reset",      0,  1,  2,  0, 0, 1, 3, 0, 0, 0, 0, C_RST,  0,  0);
    drv("idle",       1,  1,  2,  0, 0, 1, 3, 0, 0, 0, 0, C_IDLE, 0,  0);
    // load-use on rs1, then the bubble reaches EXE (rd still matches, but not valid)
    drv("lu_rs1",     1,  5,  1,  1, 1, 1, 5, 1, 0, 0, 0, C_LU,   0,  0);
    drv("lu_bubble",  1,  5,  1,  1, 1, 0, 5, 1, 0, 0, 0, C_NONE, 1,  0);
    drv("lu_rs2",     1,  1,  7,  1, 1, 1, 7, 1, 0, 0, 0, C_LU,   1,  0);
    drv("lu_after",   1,  1,  2,  0, 0, 1, 3, 0, 0, 0, 0, C_IDLE, 2,  0);
    drv("ld_x0",      1,  0,  0,  1, 1, 1, 0, 1, 0, 0, 0, C_IDLE, 2,  0);
    drv("ld_nouse",   1,  9,  9,  0, 0, 1, 9, 1, 0, 0, 0, C_IDLE, 2,  0);
    // single taken branch
    drv("br",         1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 0, C_RD,   2,  0);
    drv("br_after",   1,  1,  2,  0, 0, 0, 3, 0, 0, 0, 0, C_NONE, 2,  1);
    // branch held across a 4-cycle dmem freeze: one deferred redirect
    drv("frz_br0",    1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 1, C_FRZ,  2,  1);
    drv("frz_br1",    1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 1, C_FRZ,  3,  1);
    drv("frz_br2",    1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 1, C_FRZ,  4,  1);
    drv("frz_br3",    1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 1, C_FRZ,  5,  1);
    drv("frz_redir",  1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 0, C_RD,   6,  1);
    drv("frz_after",  1,  1,  2,  0, 0, 0, 3, 0, 0, 0, 0, C_NONE, 6,  2);
    // imem freeze beats a load-use
    drv("ifrz_lu",    1,  5,  1,  1, 0, 1, 5, 1, 0, 1, 0, C_FRZ,  6,  2);
    drv("ifrz_after", 1,  1,  2,  0, 0, 1, 3, 0, 0, 0, 0, C_IDLE, 7,  2);
    // load-use and taken together: redirect only
    drv("lu_br",      1,  5,  2,  1, 0, 1, 5, 1, 1, 0, 0, C_RD,   7,  2);
    drv("lu_br_aft",  1,  1,  2,  0, 0, 0, 3, 0, 0, 0, 0, C_NONE, 7,  3);
    // reset in the middle of a freeze with a deferred redirect
    drv("rfrz0",      1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 1, C_FRZ,  7,  3);
    drv("rfrz1",      1,  1,  2,  0, 0, 1, 3, 0, 1, 0, 1, C_FRZ,  8,  3);
    drv("rfrz_rst",   0,  1,  2,  0, 0, 1, 3, 0, 1, 0, 1, C_RST,  0,  0);
    drv("rfrz_rel",   1,  1,  2,  0, 0, 1, 3, 0, 0, 0, 0, C_IDLE, 0,  0);
    drv("rfrz_rel2",  1,  1,  2,  0, 0, 1, 3, 0, 0, 0, 0, C_IDLE, 0,  0);
    // walk stall_cnt up to all-ones and beyond
    for (int i = 0; i < 18; i++)
      drv($sformatf("sat%0d", i), 1, 1, 2, 0, 0, 1, 3, 0, 0, 1, 0, C_FRZ,
          (i > 15) ? CW'(15) : CW'(i), 0);
    drv("sat_hold",   1,  1,  2,  0, 0, 1, 3, 0, 0, 0, 0, C_IDLE, 15, 0);

    @(negedge clk);
    @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
